video_scan_gen: RTL and testbench
=================================

# video_scan_gen

Parametrised raster timing generator and framebuffer scan-out engine for the camera display path. It generates programmable sync/blanking timing, and reads a downscaled RGB565 framebuffer through a BRAM port with configurable read latency. It upscales the image by an integer power of two and drives pipeline-aligned RGB888/DE/sync to the HDMI/VGA encoder. It adds a built-in colour-bar test mode, so the display can be brought up without the camera path.

## Interface
Parameters:
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACT, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- SCALE_SH, 2, upscale shift; framebuffer is (H_ACT>>SCALE_SH) x (V_ACT>>SCALE_SH)
- RD_LAT, 1, framebuffer read latency in clocks (1..4)
- ADDR_W, 16, framebuffer address width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are CLK_25M and RST.
- CLK_25M  in  1  pixel clock
- RST  in  1  synchronous active-high reset
- mode  in  2  0 = framebuffer, 1 = colour bars, 2/3 = black
- doutb  in  16  framebuffer read data, RGB565 {R[15:11],G[10:5],B[4:0]}
- addrb  out  ADDR_W  framebuffer read address
- enb  out  1  framebuffer read enable
- hsync  out  1  horizontal sync, output-aligned
- vsync  out  1  vertical sync, output-aligned
- DE  out  1  data enable, output-aligned
- RGB  out  24  {R8,G8,B8}
- line_end  out  1  one-cycle pulse, first output cycle after DE falls
- frame_end  out  1  one-cycle pulse, first output cycle of vsync assertion

## Operation
- Horizontal counter hcnt runs 0..H_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACT+H_FP.
- Vertical counter vcnt runs 0..V_TOT-1 and advances when hcnt wraps.
- Sync is asserted for hcnt < H_SYNC and vcnt < V_SYNC.
- Active region: H_SYNC+H_BP ≤ hcnt < H_SYNC+H_BP+H_ACT, and the same form for vcnt.
- Inside the active region, x = hcnt-(H_SYNC+H_BP) and y likewise. Then:
  - addrb = (y>>SCALE_SH)*FB_W + (x>>SCALE_SH), where FB_W = H_ACT>>SCALE_SH.
  - addrb is computed incrementally with no multiplier. A line-base register adds FB_W each time y[SCALE_SH-1:0] wraps to 0. The column offset increments when x[SCALE_SH-1:0] == all-ones.
  - Both the line base and the column offset clear at the start of each frame and each line respectively.
- Outside the active region: enb = 0 and addrb holds its last value.
- enb = active && mode == 0.
- Colour expansion uses bit replication: R8 = {R5,R5[4:2]}, G8 = {G6,G6[5:4]}, B8 = {B5,B5[4:2]}.
- Colour bars: eight equal bars of width H_ACT/8, left to right: white, yellow, cyan, green, magenta, red, blue, black (components are 8'hFF/8'h00).
- Output RGB is 24'h0 whenever the aligned DE = 0, in every mode.
- mode is sampled into an internal register only at hcnt==0 && vcnt==0. A mode change takes effect at the next frame boundary, never mid-frame.

## Timing
- Stage 0 registers addrb/enb from the counters.
- doutb is valid RD_LAT clocks after stage 0.
- RGB is registered one clock later. Total latency from counters to RGB is RD_LAT+2.
- hsync, vsync, DE and the colour-bar RGB pass through a matched delay line of RD_LAT+2 stages, so all outputs are cycle-aligned.
- Reset values (the cycle after RST is sampled high): hcnt = vcnt = 0, addrb = 0, enb = 0, DE = 0, RGB = 0, line_end = 0, frame_end = 0, and hsync = vsync = ~SYNC_POL (inactive). The internal mode register = 0, and every delay-line stage clears.
- Reset asserted mid-frame aborts the scan immediately. Scanning restarts at hcnt = vcnt = 0 on the first clock after RST deasserts.
- When the last pixel of the last active line coincides with the vcnt wrap, the address counters clear. The next frame starts at addrb = 0.
- line_end and frame_end never assert during reset, or in the first RD_LAT+2 cycles after reset.

## Structure
- A shared package `video_pkg` holds:
  - the RGB565 and RGB888 field-offset constants;
  - the colour-bar palette constant array;
  - the mode encoding constants MODE_FB, MODE_BAR, MODE_BLACK;
  - the 640x480@60 default timing constants.
- One sub-module, `video_delay_line` (parametrised WIDTH, DEPTH, synchronous reset to a RESET_VAL), is used for sync/DE/bar alignment.

## Test plan
- Defaults, 2 frames: hsync period = 800 clocks, low for 96. vsync period = 420000 clocks, low for 1600. DE high for 640 clocks per line on 480 lines.
- H_ACT=16, V_ACT=8, SCALE_SH=2, mode 0: addrb sequence on line y=0..3 is 0,0,0,0,1,1,1,1,2,…,3. Line y=4 starts at 4, and the last address in the frame is 7.
- RD_LAT=3, with a memory model returning doutb = 16'hF800 at addr 0: the first DE pixel has RGB = 24'hFF0000. 16'h07E0 gives 24'h00FF00, and 16'h001F gives 24'h0000FF. DE and RGB are aligned in the same cycle.
- mode 1: the pixel at x=0 is 24'hFFFFFF, at x=H_ACT/8 it is 24'hFFFF00, and the last bar is 24'h000000. enb stays 0 throughout.
- Switch mode 0→1 mid-frame: the output remains framebuffer data until the frame end, and bars appear from the first active pixel of the next frame.
- Assert RST for 1 clock mid-line with SYNC_POL=1: hsync and vsync go to 0 and DE/RGB to 0 on the next clock. The first line_end arrives H_SYNC+H_BP+H_ACT+RD_LAT+2 clocks after RST deasserts.

Source files
------------

// File: rtl/video_pkg.sv
// ============================================================================
// video_pkg : shared constants, colour formats and helpers for scan-out
// Revision  : 1.0
// ============================================================================
`default_nettype none

package video_pkg;

  typedef logic [23:0] rgb888_t;
  typedef logic [15:0] rgb565_t;

  localparam int R565_LSB = 11;
  localparam int G565_LSB = 5;
  localparam int B565_LSB = 0;
  localparam int R888_LSB = 16;
  localparam int G888_LSB = 8;
  localparam int B888_LSB = 0;

  localparam logic [1:0] MODE_FB    = 2'd0;
  localparam logic [1:0] MODE_BAR   = 2'd1;
  localparam logic [1:0] MODE_BLACK = 2'd2;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb888_t BAR_PALETTE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    rgb888_t    o;
    r = p[R565_LSB +: 5];
    g = p[G565_LSB +: 6];
    b = p[B565_LSB +: 5];
    o = '0;
    o[R888_LSB +: 8] = {r, r[4:2]};
    o[G888_LSB +: 8] = {g, g[5:4]};
    o[B888_LSB +: 8] = {b, b[4:2]};
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_delay_line.sv
// ============================================================================
// video_delay_line : fixed-depth register pipeline with synchronous reset
// Revision         : 1.0
// ============================================================================
`default_nettype none

module video_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/video_scan_gen.sv
// ============================================================================
// video_scan_gen : raster timing, framebuffer scan-out with 2^N upscale, bars
// Revision       : 1.0
// ============================================================================
`default_nettype none

module video_scan_gen
  import video_pkg::*;
#(
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int SCALE_SH = 2,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              CLK_25M,
  input  logic              RST,
  input  logic [1:0]        mode,
  input  logic [15:0]       doutb,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  output logic              hsync,
  output logic              vsync,
  output logic              DE,
  output logic [23:0]       RGB,
  output logic              line_end,
  output logic              frame_end
);

  localparam int c_h_tot = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int c_v_tot = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int c_hw    = $clog2(c_h_tot);
  localparam int c_vw    = $clog2(c_v_tot);

  localparam logic [c_hw-1:0]   c_h_last  = c_hw'(c_h_tot - 1);
  localparam logic [c_vw-1:0]   c_v_last  = c_vw'(c_v_tot - 1);
  localparam logic [c_hw-1:0]   c_h_sync  = c_hw'(H_SYNC);
  localparam logic [c_vw-1:0]   c_v_sync  = c_vw'(V_SYNC);
  localparam logic [c_hw-1:0]   c_h_start = c_hw'(H_SYNC + H_BP);
  localparam logic [c_hw-1:0]   c_h_end   = c_hw'(H_SYNC + H_BP + H_ACT);
  localparam logic [c_vw-1:0]   c_v_start = c_vw'(V_SYNC + V_BP);
  localparam logic [c_vw-1:0]   c_v_end   = c_vw'(V_SYNC + V_BP + V_ACT);
  localparam logic [c_hw-1:0]   c_xmask   = c_hw'((1 << SCALE_SH) - 1);
  localparam logic [c_vw-1:0]   c_ymask   = c_vw'((1 << SCALE_SH) - 1);
  localparam logic [ADDR_W-1:0] c_fb_w    = ADDR_W'(H_ACT >> SCALE_SH);
  localparam logic [c_hw-1:0]   c_bar_last = c_hw'(H_ACT / 8 - 1);
  localparam logic [7:0]        c_dl_rst  = {~SYNC_POL, ~SYNC_POL, 6'b0};

  logic [c_hw-1:0]   hcnt_q, hcnt_d, bar_cnt_q, bar_cnt_d;
  logic [c_vw-1:0]   vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] col_q, col_d, base_q, base_d, addrb_q, addrb_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [1:0]        mode_q, mode_d;
  logic              enb_q, enb_d;
  logic              hsync_q, vsync_q, de_q, line_end_q, frame_end_q;
  logic              line_end_d, frame_end_d;
  logic [23:0]       rgb_q, rgb_d;

  logic [c_hw-1:0] w_x;
  logic [c_vw-1:0] w_y;
  logic            w_h_last, w_v_last, w_h_act, w_v_act, w_act;
  logic            w_x_sub_full, w_y_sub_full, w_hs, w_vs;
  logic [7:0]      w_dl_in, w_dl_out;
  logic            w_dl_hs, w_dl_vs, w_dl_de;
  logic [1:0]      w_dl_mode;
  logic [2:0]      w_dl_bar;

  assign w_h_last     = (hcnt_q == c_h_last);
  assign w_v_last     = (vcnt_q == c_v_last);
  assign w_h_act      = (hcnt_q >= c_h_start) && (hcnt_q < c_h_end);
  assign w_v_act      = (vcnt_q >= c_v_start) && (vcnt_q < c_v_end);
  assign w_act        = w_h_act && w_v_act;
  assign w_x          = hcnt_q - c_h_start;
  assign w_y          = vcnt_q - c_v_start;
  assign w_x_sub_full = ((w_x & c_xmask) == c_xmask);
  assign w_y_sub_full = ((w_y & c_ymask) == c_ymask);
  assign w_hs         = (hcnt_q < c_h_sync) ? SYNC_POL : ~SYNC_POL;
  assign w_vs         = (vcnt_q < c_v_sync) ? SYNC_POL : ~SYNC_POL;

  always_comb begin
    hcnt_d    = w_h_last ? '0 : hcnt_q + 1'b1;
    vcnt_d    = vcnt_q;
    base_d    = base_q;
    col_d     = '0;
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (w_h_last) begin
      vcnt_d = w_v_last ? '0 : vcnt_q + 1'b1;
      // Frame wrap wins over the line-base step so the next frame starts at 0
      if (w_v_last)                  base_d = '0;
      else if (w_v_act && w_y_sub_full) base_d = base_q + c_fb_w;
    end
    if (w_h_act) begin
      col_d = w_x_sub_full ? col_q + 1'b1 : col_q;
      if (bar_cnt_q == c_bar_last) begin
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
        bar_idx_d = bar_idx_q;
      end
    end
    addrb_d = w_act ? base_q + col_q : addrb_q;
    enb_d   = w_act && (mode_q == MODE_FB);
    mode_d  = (hcnt_q == '0 && vcnt_q == '0) ? mode : mode_q;
  end

  // Sync, DE, mode and bar index travel alongside the BRAM read latency
  assign w_dl_in = {w_hs, w_vs, w_act, mode_q, bar_idx_q};

  video_delay_line #(
    .WIDTH     (8),
    .DEPTH     (RD_LAT + 1),
    .RESET_VAL (c_dl_rst)
  ) u_align (
    .clk_i (CLK_25M),
    .rst_i (RST),
    .d_i   (w_dl_in),
    .q_o   (w_dl_out)
  );

  assign {w_dl_hs, w_dl_vs, w_dl_de, w_dl_mode, w_dl_bar} = w_dl_out;

  always_comb begin
    rgb_d = '0;
    if (w_dl_de) begin
      case (w_dl_mode)
        MODE_FB:    rgb_d = rgb565_to_888(doutb);
        MODE_BAR:   rgb_d = BAR_PALETTE[w_dl_bar];
        MODE_BLACK: rgb_d = '0;
        default:    rgb_d = '0;
      endcase
    end
    line_end_d  = de_q & ~w_dl_de;
    frame_end_d = (w_dl_vs == SYNC_POL) && (vsync_q != SYNC_POL);
  end

  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      col_q       <= '0;
      base_q      <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      mode_q      <= MODE_FB;
      addrb_q     <= '0;
      enb_q       <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      col_q       <= col_d;
      base_q      <= base_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      mode_q      <= mode_d;
      addrb_q     <= addrb_d;
      enb_q       <= enb_d;
      hsync_q     <= w_dl_hs;
      vsync_q     <= w_dl_vs;
      de_q        <= w_dl_de;
      rgb_q       <= rgb_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign addrb     = addrb_q;
  assign enb       = enb_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign DE        = de_q;
  assign RGB       = rgb_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

endmodule

`default_nettype wire

// File: tb/tb_video_scan_gen.sv
// ============================================================================
// tb_video_scan_gen : small-raster bench with a cycle-indexed reference model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_video_scan_gen;

  localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACT = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam bit POL = 1'b1;
  localparam int SCALE_SH = 2, RD_LAT = 3, ADDR_W = 16;
  localparam int L     = RD_LAT + 2;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int H_ST  = H_SYNC + H_BP;
  localparam int V_ST  = V_SYNC + V_BP;
  localparam int FB_W  = H_ACT >> SCALE_SH;

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic [15:0]       doutb;
  logic [ADDR_W-1:0] addrb;
  logic              enb, hsync, vsync, DE, line_end, frame_end;
  logic [23:0]       RGB;

  video_scan_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(POL), .SCALE_SH(SCALE_SH), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .CLK_25M(clk), .RST(RST), .mode(mode), .doutb(doutb),
    .addrb(addrb), .enb(enb), .hsync(hsync), .vsync(vsync), .DE(DE),
    .RGB(RGB), .line_end(line_end), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  logic [15:0] mem   [8];
  logic [15:0] mpipe [RD_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mem[addrb[2:0]];
    for (int i = 1; i < RD_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign doutb = mpipe[RD_LAT-1];

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int fmode [64];
  int n = 0;
  int last_addr = 0;
  bit armed = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ex5(input int v);
    return 8'(v * 8 + v / 4);
  endfunction

  function automatic logic [7:0] ex6(input int v);
    return 8'(v * 4 + v / 16);
  endfunction

  // Expected output pixel for raster position p (cycles since reset release)
  function automatic void src(input int p, output logic de, output logic hs,
                              output logic vs, output logic [23:0] rgb);
    int h, v, x, y;
    logic [15:0] px;
    de = 1'b0; hs = ~POL; vs = ~POL; rgb = 24'h0;
    if (p >= 0) begin
      h  = p % H_TOT;
      v  = (p / H_TOT) % V_TOT;
      hs = (h < H_SYNC) ? POL : ~POL;
      vs = (v < V_SYNC) ? POL : ~POL;
      de = (h >= H_ST) && (h < H_ST + H_ACT) && (v >= V_ST) && (v < V_ST + V_ACT);
      if (de) begin
        x = h - H_ST;
        y = v - V_ST;
        if (fmode[p / FRAME] == 0) begin
          px  = mem[(y >> SCALE_SH) * FB_W + (x >> SCALE_SH)];
          rgb = {ex5(int'(px[15:11])), ex6(int'(px[10:5])), ex5(int'(px[4:0]))};
        end else if (fmode[p / FRAME] == 1) begin
          rgb = bars[x / (H_ACT / 8)];
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at n=%0d observed=%0h expected=%0h", tag, n, obs, exp_v);
    end
  endtask

  task automatic tick();
    logic rst_s, de, hs, vs, dep, hsp, vsp;
    logic [23:0] rgb, rgbp;
    int p0, h, v, ea, ee;
    rst_s = RST;
    if (armed && !rst_s && (n % FRAME) == 0 && (n / FRAME) < 64) fmode[n / FRAME] = int'(mode);
    @(posedge clk);
    if (rst_s) begin
      n = 0;
      armed = 1;
    end else begin
      n++;
    end
    #1;
    if (armed) begin
      src(n - L, de, hs, vs, rgb);
      src(n - L - 1, dep, hsp, vsp, rgbp);
      chk("DE", 32'(DE), 32'(de));
      chk("HSYNC", 32'(hsync), 32'(hs));
      chk("VSYNC", 32'(vsync), 32'(vs));
      chk("RGB", 32'(RGB), 32'(rgb));
      chk("LINE_END", 32'(line_end), 32'(dep & ~de));
      chk("FRAME_END", 32'(frame_end), 32'((vs == POL) && (vsp != POL)));
      if (rst_s) begin
        ea = 0; ee = 0; last_addr = 0;
      end else begin
        p0 = n - 1;
        h  = p0 % H_TOT;
        v  = (p0 / H_TOT) % V_TOT;
        if (h >= H_ST && h < H_ST + H_ACT && v >= V_ST && v < V_ST + V_ACT) begin
          ea = ((v - V_ST) >> SCALE_SH) * FB_W + ((h - H_ST) >> SCALE_SH);
          last_addr = ea;
          ee = (fmode[p0 / FRAME] == 0) ? 1 : 0;
        end else begin
          ea = last_addr;
          ee = 0;
        end
      end
      chk("ADDRB", 32'(addrb), 32'(ea));
      chk("ENB", 32'(enb), 32'(ee));
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic pulse_reset(input int cycles);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    run(cycles);
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) fmode[i] = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);

    // Power-on reset, then two framebuffer frames
    pulse_reset(3);
    run(2 * FRAME + 40);

    // Primary colours at the first three framebuffer words
    pulse_reset(1);
    mem[0] = 16'hF800; mem[1] = 16'h07E0; mem[2] = 16'h001F;
    run(FRAME + 24);

    // Switch to bars in the middle of an active region
    run(100);
    mode = 2'd1;
    run(2 * FRAME);

    // Randomised mode changes across several frames
    for (int f = 0; f < 5; f++) begin
      run($urandom_range(20, FRAME - 20));
      mode = 2'($urandom_range(0, 3));
    end
    run(FRAME);

    // Single-cycle resets at random points in the raster
    for (int k = 0; k < 3; k++) begin
      mode = 2'($urandom_range(0, 1));
      pulse_reset(1);
      run($urandom_range(FRAME + 10, 2 * FRAME + 50));
    end

    mode = 2'd0;
    pulse_reset(2);
    run(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
